// File: rtl/regfile_sb_module_pkg.sv
// Shared RV32 register-file definitions: architectural register numbers
// and address helpers used by the register array and the scoreboard.
package regfile_sb_module_pkg;

  localparam int XLEN_RV32 = 32;
  localparam int REG_ZERO  = 0;
  localparam int REG_SP    = 2;

  // True when a zero-extended address selects an implemented register.
  function automatic logic in_range(input int unsigned addr, input int unsigned nregs);
    return addr < nregs;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy scoreboard: tracks outstanding writes between issue and
// writeback, drives issue back-pressure, per-port busy flags and a busy count.
module regfile_scoreboard
  import regfile_sb_module_pkg::*;
#(
  parameter int NREGS  = 32,
  parameter int NRP    = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRP*AW-1:0] ra,
  output logic [NRP-1:0]    rbusy,
  input  logic              iss_valid,
  input  logic [AW-1:0]     iss_rd,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [AW-1:0]     wb_addr,
  output logic [AW:0]       busy_cnt,
  output logic              err_wb
);

  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             iss_in;
  logic             wb_in;
  logic             iss_busy;
  logic             wb_busy;
  logic             iss_acc;
  logic             wb_act;
  logic             inc;
  logic             dec;

  assign iss_in   = in_range(32'(iss_rd), NREGS);
  assign wb_in    = in_range(32'(wb_addr), NREGS);
  assign iss_busy = iss_in ? busy[iss_rd] : 1'b0;
  assign wb_busy  = wb_in ? busy[wb_addr] : 1'b0;

  // A writeback to the same register frees the slot for an issue in that cycle.
  assign iss_ready = ~iss_busy | (wb_valid & (wb_addr == iss_rd)) | (iss_rd == AW'(REG_ZERO));
  assign iss_acc   = iss_valid & iss_ready & (iss_rd != AW'(REG_ZERO)) & iss_in;
  assign wb_act    = wb_valid & (wb_addr != AW'(REG_ZERO)) & wb_in;

  // Count moves only when the population of set bits actually changes.
  assign inc = iss_acc & (~iss_busy | (wb_act & (wb_addr == iss_rd)));
  assign dec = wb_act & wb_busy;

  always_comb begin
    busy_nxt = busy;
    if (wb_act) busy_nxt[wb_addr] = 1'b0;
    if (iss_acc) busy_nxt[iss_rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
      err_wb   <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (inc && !dec) busy_cnt <= busy_cnt + CNT_ONE;
      else if (dec && !inc) busy_cnt <= busy_cnt - CNT_ONE;
      if (wb_act && !wb_busy) err_wb <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rbusy
    logic [AW-1:0] a;
    logic          a_busy;
    assign a        = ra[k*AW +: AW];
    assign a_busy   = in_range(32'(a), NREGS) ? busy[a] : 1'b0;
    assign rbusy[k] = a_busy & ~(BYPASS & wb_valid & (wb_addr == a));
  end

endmodule

// File: rtl/regfile_sb_module.sv
// RV32 integer register file: NRP combinational read ports with optional
// writeback bypass, one writeback port, a debug preload port and a scoreboard.
module regfile_sb_module
  import regfile_sb_module_pkg::*;
#(
  parameter int              XLEN    = XLEN_RV32,
  parameter int              NREGS   = 32,
  parameter int              NRP     = 2,
  parameter bit              BYPASS  = 1'b1,
  parameter logic [XLEN-1:0] SP_INIT = '0,
  localparam int             AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rdata,
  output logic [NRP-1:0]      rbusy,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ready,
  input  logic                wb_valid,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                dbg_we,
  input  logic [AW-1:0]       dbg_addr,
  input  logic [XLEN-1:0]     dbg_data,
  output logic [AW:0]         busy_cnt,
  output logic                err_wb
);

  logic [XLEN-1:0] regs [NREGS];
  logic            wb_act;
  logic            dbg_act;

  assign wb_act  = wb_valid & (wb_addr != AW'(REG_ZERO)) & in_range(32'(wb_addr), NREGS);
  // Writeback owns the port when both target the same register.
  assign dbg_act = dbg_we & (dbg_addr != AW'(REG_ZERO)) & in_range(32'(dbg_addr), NREGS)
                 & ~(wb_valid & (wb_addr == dbg_addr));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= (i == REG_SP) ? SP_INIT : '0;
    end else begin
      if (dbg_act) regs[dbg_addr] <= dbg_data;
      if (wb_act) regs[wb_addr] <= wb_data;
    end
  end

  for (genvar k = 0; k < NRP; k++) begin : g_rd
    logic [AW-1:0]   a;
    logic            hit;
    logic [XLEN-1:0] rd;
    assign a   = ra[k*AW +: AW];
    assign hit = BYPASS & wb_valid & (wb_addr == a);
    always_comb begin
      rd = '0;
      if (a != AW'(REG_ZERO) && in_range(32'(a), NREGS)) rd = hit ? wb_data : regs[a];
    end
    assign rdata[k*XLEN +: XLEN] = rd;
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NRP    (NRP),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .rbusy     (rbusy),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .busy_cnt  (busy_cnt),
    .err_wb    (err_wb)
  );

endmodule

// File: tb/tb_regfile_sb_module.sv
// Directed bench for regfile_sb_module: a bypassing and a non-bypassing
// instance share all inputs so both read behaviours are observed together.
module tb_regfile_sb_module;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  ra;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        dbg_we;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  logic [63:0] rdata1, rdata0;
  logic [1:0]  rbusy1, rbusy0;
  logic        rdy1, rdy0;
  logic [5:0]  cnt1, cnt0;
  logic        err1, err0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_sb_module #(.XLEN(32), .NREGS(32), .NRP(2), .BYPASS(1'b1), .SP_INIT(32'h8000)) u_b1 (
    .clk(clk), .reset(reset), .ra(ra), .rdata(rdata1), .rbusy(rbusy1),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(rdy1),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .busy_cnt(cnt1), .err_wb(err1)
  );

  regfile_sb_module #(.XLEN(32), .NREGS(32), .NRP(2), .BYPASS(1'b0), .SP_INIT(32'h8000)) u_b0 (
    .clk(clk), .reset(reset), .ra(ra), .rdata(rdata0), .rbusy(rbusy0),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(rdy0),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .busy_cnt(cnt0), .err_wb(err0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; iss_valid = 1'b0; iss_rd = '0;
    wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
    dbg_we = 1'b0; dbg_addr = '0; dbg_data = '0;
  endtask

  task automatic test_reset();
    idle(); ra = '0; reset = 1'b1;
    step();
    reset = 1'b0; ra = {5'd3, 5'd2};
    #1;
    n_cmp++; if (rdata1[31:0] !== 32'h00008000) begin n_err++; $display("FAIL reset_sp got %h exp %h", rdata1[31:0], 32'h8000); end
    n_cmp++; if (rdata1[63:32] !== 32'h0) begin n_err++; $display("FAIL reset_x3 got %h exp 0", rdata1[63:32]); end
    n_cmp++; if (cnt1 !== 6'd0) begin n_err++; $display("FAIL reset_cnt got %0d exp 0", cnt1); end
    n_cmp++; if (err1 !== 1'b0) begin n_err++; $display("FAIL reset_err got %b exp 0", err1); end
    for (int r = 0; r < 32; r++) begin
      iss_rd = 5'(r);
      #1;
      n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL reset_ready rd=%0d got %b exp 1", r, rdy1); end
    end
    iss_rd = '0;
  endtask

  task automatic test_x0();
    idle(); ra = {5'd0, 5'd0};
    wb_valid = 1'b1; wb_addr = 5'd0; wb_data = 32'd5;
    dbg_we = 1'b1; dbg_addr = 5'd0; dbg_data = 32'd5;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1;
    n_cmp++; if (rdata1[31:0] !== 32'h0) begin n_err++; $display("FAIL x0_bypass got %h exp 0", rdata1[31:0]); end
    n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL x0_ready got %b exp 1", rdy1); end
    step();
    idle();
    #1;
    n_cmp++; if (rdata1[31:0] !== 32'h0 || rdata0[31:0] !== 32'h0) begin n_err++; $display("FAIL x0_read got %h/%h exp 0", rdata1[31:0], rdata0[31:0]); end
    n_cmp++; if (cnt1 !== 6'd0) begin n_err++; $display("FAIL x0_cnt got %0d exp 0", cnt1); end
    n_cmp++; if (err1 !== 1'b0) begin n_err++; $display("FAIL x0_err got %b exp 0", err1); end
    n_cmp++; if (rbusy1[0] !== 1'b0) begin n_err++; $display("FAIL x0_rbusy got %b exp 0", rbusy1[0]); end
  endtask

  task automatic test_bypass();
    idle(); ra = {5'd0, 5'd5};
    dbg_we = 1'b1; dbg_addr = 5'd5; dbg_data = 32'h11111111;
    iss_valid = 1'b1; iss_rd = 5'd5;
    step();
    idle();
    #1;
    n_cmp++; if (cnt1 !== 6'd1) begin n_err++; $display("FAIL byp_cnt_issue got %0d exp 1", cnt1); end
    n_cmp++; if (rbusy1[0] !== 1'b1 || rbusy0[0] !== 1'b1) begin n_err++; $display("FAIL byp_rbusy got %b/%b exp 1/1", rbusy1[0], rbusy0[0]); end
    wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'hAABBCCDD;
    #1;
    n_cmp++; if (rdata1[31:0] !== 32'hAABBCCDD) begin n_err++; $display("FAIL byp_on got %h exp aabbccdd", rdata1[31:0]); end
    n_cmp++; if (rdata0[31:0] !== 32'h11111111) begin n_err++; $display("FAIL byp_off got %h exp 11111111", rdata0[31:0]); end
    n_cmp++; if (rbusy1[0] !== 1'b0) begin n_err++; $display("FAIL byp_rbusy_on got %b exp 0", rbusy1[0]); end
    n_cmp++; if (rbusy0[0] !== 1'b1) begin n_err++; $display("FAIL byp_rbusy_off got %b exp 1", rbusy0[0]); end
    step();
    idle();
    #1;
    n_cmp++; if (rdata0[31:0] !== 32'hAABBCCDD) begin n_err++; $display("FAIL byp_off_next got %h exp aabbccdd", rdata0[31:0]); end
    n_cmp++; if (cnt1 !== 6'd0 || cnt0 !== 6'd0) begin n_err++; $display("FAIL byp_cnt_wb got %0d/%0d exp 0", cnt1, cnt0); end
    n_cmp++; if (err1 !== 1'b0) begin n_err++; $display("FAIL byp_err got %b exp 0", err1); end
  endtask

  task automatic test_issue();
    idle(); ra = {5'd7, 5'd0};
    iss_valid = 1'b1; iss_rd = 5'd7;
    step();
    idle();
    #1;
    n_cmp++; if (cnt1 !== 6'd1) begin n_err++; $display("FAIL iss_cnt got %0d exp 1", cnt1); end
    n_cmp++; if (rbusy1[1] !== 1'b1) begin n_err++; $display("FAIL iss_rbusy got %b exp 1", rbusy1[1]); end
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1;
    n_cmp++; if (rdy1 !== 1'b0) begin n_err++; $display("FAIL iss_stall got %b exp 0", rdy1); end
    step();
    n_cmp++; if (cnt1 !== 6'd1) begin n_err++; $display("FAIL iss_stall_cnt got %0d exp 1", cnt1); end
    wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'h77;
    #1;
    n_cmp++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL iss_wb_ready got %b exp 1", rdy1); end
    step();
    idle();
    #1;
    n_cmp++; if (cnt1 !== 6'd1) begin n_err++; $display("FAIL iss_wb_cnt got %0d exp 1", cnt1); end
    n_cmp++; if (rbusy1[1] !== 1'b1) begin n_err++; $display("FAIL iss_wb_busy got %b exp 1", rbusy1[1]); end
    n_cmp++; if (rdata1[63:32] !== 32'h77) begin n_err++; $display("FAIL iss_wb_data got %h exp 77", rdata1[63:32]); end
    n_cmp++; if (err1 !== 1'b0) begin n_err++; $display("FAIL iss_wb_err got %b exp 0", err1); end
  endtask

  task automatic test_err_and_dbg();
    idle(); ra = {5'd4, 5'd9};
    wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'd14;
    step();
    idle();
    #1;
    n_cmp++; if (rdata1[31:0] !== 32'd14) begin n_err++; $display("FAIL err_data got %0d exp 14", rdata1[31:0]); end
    n_cmp++; if (err1 !== 1'b1) begin n_err++; $display("FAIL err_set got %b exp 1", err1); end
    n_cmp++; if (cnt1 !== 6'd1) begin n_err++; $display("FAIL err_cnt got %0d exp 1", cnt1); end
    wb_valid = 1'b1; wb_addr = 5'd4; wb_data = 32'h44;
    dbg_we = 1'b1; dbg_addr = 5'd4; dbg_data = 32'hDEAD;
    step();
    idle();
    #1;
    n_cmp++; if (rdata1[63:32] !== 32'h44) begin n_err++; $display("FAIL dbg_wb_prio got %h exp 44", rdata1[63:32]); end
    dbg_we = 1'b1; dbg_addr = 5'd4; dbg_data = 32'h55;
    #1;
    n_cmp++; if (rdata1[63:32] !== 32'h44) begin n_err++; $display("FAIL dbg_no_bypass got %h exp 44", rdata1[63:32]); end
    step();
    idle();
    #1;
    n_cmp++; if (rdata1[63:32] !== 32'h55) begin n_err++; $display("FAIL dbg_write got %h exp 55", rdata1[63:32]); end
    n_cmp++; if (err1 !== 1'b1 || cnt1 !== 6'd1) begin n_err++; $display("FAIL err_sticky got err=%b cnt=%0d exp 1/1", err1, cnt1); end
  endtask

  task automatic test_reset_mid();
    idle(); ra = {5'd7, 5'd10};
    iss_valid = 1'b1; iss_rd = 5'd10;
    step();
    iss_rd = 5'd11;
    step();
    idle();
    #1;
    n_cmp++; if (cnt1 !== 6'd3) begin n_err++; $display("FAIL mid_cnt got %0d exp 3", cnt1); end
    reset = 1'b1;
    wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'h99;
    iss_valid = 1'b1; iss_rd = 5'd13;
    step();
    idle();
    #1;
    n_cmp++; if (cnt1 !== 6'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d exp 0", cnt1); end
    n_cmp++; if (err1 !== 1'b0) begin n_err++; $display("FAIL mid_rst_err got %b exp 0", err1); end
    n_cmp++; if (rdata1[31:0] !== 32'h0) begin n_err++; $display("FAIL mid_rst_x10 got %h exp 0", rdata1[31:0]); end
    n_cmp++; if (rbusy1 !== 2'b00) begin n_err++; $display("FAIL mid_rst_rbusy got %b exp 00", rbusy1); end
    ra = {5'd9, 5'd2};
    #1;
    n_cmp++; if (rdata1[31:0] !== 32'h00008000) begin n_err++; $display("FAIL mid_rst_sp got %h exp 8000", rdata1[31:0]); end
    n_cmp++; if (rdata1[63:32] !== 32'h0) begin n_err++; $display("FAIL mid_rst_x9 got %h exp 0", rdata1[63:32]); end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_bypass();
    test_issue();
    test_err_and_dbg();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
